// File: rtl/mmio_responder_if.sv
// CPU-side bus and TX drain port of the MMIO responder; clk, reset and the tri-state
// read bus stay outside the interface.
interface mmio_responder_if;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] wdata;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave  (input  mem_cmd, mem_addr, wdata, tx_ready,
                    output tx_data, tx_valid);
    modport master (output mem_cmd, mem_addr, wdata, tx_ready,
                    input  tx_data, tx_valid);
endinterface

// File: rtl/mmio_responder.sv
// MMIO responder (switches, LEDs, timer/compare, TX FIFO); reads combinational, side effects on first edge of an access.
// TX port: head word held until tx_valid & tx_ready; pushes to a full FIFO without a pop are dropped and flagged.
module mmio_responder #(
    parameter int FIFO_DEPTH = 4,
    parameter int SW_WIDTH   = 8,
    parameter int LED_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mmio_responder_if.slave      bus,
    output wire  [15:0]          mem_data,
    input  logic [SW_WIDTH-1:0]  sw,
    output logic [LED_WIDTH-1:0] led,
    output logic                 irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] CMD_RD = 2'b10;
    localparam logic [1:0] CMD_WR = 2'b01;

    logic [1:0]           prev_cmd_q, prev_cmd_d;
    logic [8:0]           prev_addr_q, prev_addr_d;
    logic [SW_WIDTH-1:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [15:0]          timer_q, timer_d, cmp_q, cmp_d;
    logic                 tflag_q, tflag_d, ovf_q, ovf_d;
    logic [1:0]           st_hold_q, st_hold_d;
    logic [15:0]          fifo_q [FIFO_DEPTH];
    logic [15:0]          fifo_d [FIFO_DEPTH];
    logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic        hit, same, first, rd_hit, wr_fe, rd_fe, st_cont;
    logic        full, empty, push, pop, accept;
    logic [7:0]  offset;
    logic [15:0] status, rdata;

    always_comb begin
        hit     = bus.mem_addr[8];
        offset  = bus.mem_addr[7:0];
        same    = (prev_cmd_q == bus.mem_cmd) && (prev_addr_q == bus.mem_addr);
        first   = hit && !same;
        rd_hit  = hit && (bus.mem_cmd == CMD_RD);
        wr_fe   = first && (bus.mem_cmd == CMD_WR);
        rd_fe   = first && (bus.mem_cmd == CMD_RD);
        // A held STATUS read keeps showing the sticky bits it cleared on its first edge.
        st_cont = rd_hit && same && (offset == 8'h04);
        full    = (count_q == CW'(FIFO_DEPTH));
        empty   = (count_q == '0);
        pop     = !empty && bus.tx_ready;
        push    = wr_fe && (offset == 8'h05);
        accept  = push && (!full || pop);
        status  = {9'b0, 4'(count_q), ovf_q | (st_cont & st_hold_q[1]), full,
                   tflag_q | (st_cont & st_hold_q[0])};
        case (offset)
            8'h00:   rdata = 16'(sw_sync_q);
            8'h01:   rdata = 16'(led_q);
            8'h02:   rdata = timer_q;
            8'h03:   rdata = cmp_q;
            8'h04:   rdata = status;
            default: rdata = 16'h0000;
        endcase
    end

    assign mem_data     = (reset_n && rd_hit) ? rdata : 16'hzzzz;
    assign bus.tx_data  = fifo_q[rptr_q];
    assign bus.tx_valid = !empty;
    assign led          = led_q;
    assign irq          = tflag_q;

    always_comb begin
        prev_cmd_d  = bus.mem_cmd;
        prev_addr_d = bus.mem_addr;
        sw_meta_d   = sw;
        sw_sync_d   = sw_meta_q;
        led_d       = led_q;
        cmp_d       = cmp_q;
        timer_d     = timer_q + 16'd1;
        tflag_d     = tflag_q;
        ovf_d       = ovf_q;
        st_hold_d   = st_hold_q;
        fifo_d      = fifo_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;

        if (wr_fe && offset == 8'h01) led_d = bus.wdata[LED_WIDTH-1:0];
        if (wr_fe && offset == 8'h03) cmp_d = bus.wdata;
        if (rd_fe && offset == 8'h04) begin
            tflag_d   = 1'b0;
            ovf_d     = 1'b0;
            st_hold_d = {ovf_q, tflag_q};
        end
        // Setting beats the STATUS read-clear on the same edge.
        if (timer_q == cmp_q)         tflag_d = 1'b1;
        if (push && full && !pop)     ovf_d   = 1'b1;
        if (accept) begin
            fifo_d[wptr_q] = bus.wdata;
            wptr_d         = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        count_d = count_q + CW'(accept) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_cmd_q  <= 2'b00;
            prev_addr_q <= '0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            led_q       <= '0;
            timer_q     <= 16'h0000;
            cmp_q       <= 16'hFFFF;
            tflag_q     <= 1'b0;
            ovf_q       <= 1'b0;
            st_hold_q   <= 2'b00;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 16'h0000;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            prev_cmd_q  <= prev_cmd_d;
            prev_addr_q <= prev_addr_d;
            sw_meta_q   <= sw_meta_d;
            sw_sync_q   <= sw_sync_d;
            led_q       <= led_d;
            timer_q     <= timer_d;
            cmp_q       <= cmp_d;
            tflag_q     <= tflag_d;
            ovf_q       <= ovf_d;
            st_hold_q   <= st_hold_d;
            fifo_q      <= fifo_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end
endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: stimulus pushes expected read data and TX words into
// queues; a negedge monitor pops and compares whenever a read is on the bus or a TX word is taken.
module tb_mmio_responder;
    localparam logic [1:0] NOP = 2'b00, RD = 2'b10, WR = 2'b01;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        irq;
    wire  [15:0] mem_data;
    logic [15:0] cyc;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] rdq_val [$];
    bit          rdq_z   [$];
    logic [15:0] txq     [$];

    always #5 clk = ~clk;

    mmio_responder_if bus ();

    mmio_responder #(.FIFO_DEPTH(4), .SW_WIDTH(8), .LED_WIDTH(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .mem_data (mem_data),
        .sw       (sw),
        .led      (led),
        .irq      (irq)
    );

    // Reference cycle count since reset release: the expected TIMER value.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 16'h0000;
        else          cyc <= cyc + 16'h0001;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_z(input string name, input logic [15:0] act);
        n_cmp++;
        if (!((act === 16'hzzzz) || (act === 16'h0000))) begin
            n_bad++;
            $display("FAIL %s: got %h, expected undriven (z)", name, act);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        bus.mem_cmd  = c;
        bus.mem_addr = a;
        bus.wdata    = d;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_rd(input logic [15:0] v);
        rdq_val.push_back(v);
        rdq_z.push_back(1'b0);
    endtask

    task automatic exp_rd_z();
        rdq_val.push_back(16'h0000);
        rdq_z.push_back(1'b1);
    endtask

    task automatic wait_cyc(input logic [15:0] t);
        int b = 0;
        while (cyc != t && b < 300) begin
            step(1);
            b++;
        end
        if (cyc != t) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_timer: reached %h, expected %h", cyc, t);
        end
    endtask

    task automatic drain(input string name);
        int b = 0;
        bus.tx_ready = 1'b1;
        while (bus.tx_valid && b < 20) begin
            step(1);
            b++;
        end
        bus.tx_ready = 1'b0;
        chk(name, 16'(bus.tx_valid), 16'h0000);
    endtask

    always @(negedge clk) begin
        logic [15:0] ev;
        bit          ez;
        if (reset_n && bus.mem_cmd == RD) begin
            if (rdq_val.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL read_unexpected: got %h, expected no read", mem_data);
            end else begin
                ev = rdq_val.pop_front();
                ez = rdq_z.pop_front();
                if (ez) chk_z("read_ram_space", mem_data);
                else    chk("read_data", mem_data, ev);
            end
        end
        if (reset_n && bus.tx_valid && bus.tx_ready) begin
            if (txq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_unexpected: got %h, expected no word", bus.tx_data);
            end else begin
                chk("tx_word", bus.tx_data, txq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        sw           = 8'h00;
        bus.tx_ready = 1'b0;
        drive(RD, 9'h103, 16'h0000);
        step(2);
        chk_z("rst_mem_data", mem_data);
        chk("rst_led", 16'(led), 16'h0000);
        chk("rst_irq", 16'(irq), 16'h0000);
        chk("rst_tx_valid", 16'(bus.tx_valid), 16'h0000);
        chk("rst_tx_data", bus.tx_data, 16'h0000);
        drive(NOP, 9'h000, 16'h0000);
        @(negedge clk) reset_n = 1'b1;
        step(1);

        // TIMER read held 3 cycles, then NOP at same address, then RAM-space read.
        exp_rd(cyc); exp_rd(cyc + 16'd1); exp_rd(cyc + 16'd2);
        drive(RD, 9'h102, 16'h0000);
        step(3);
        drive(NOP, 9'h102, 16'h0000);
        @(negedge clk) chk_z("nop_mem_data", mem_data);
        step(1);
        exp_rd_z(); exp_rd_z();
        drive(RD, 9'h002, 16'h0000);
        step(2);

        // LED write held 4 cycles, read back.
        drive(WR, 9'h101, 16'h00A5);
        step(1);
        chk("led_first_edge", 16'(led), 16'h00A5);
        step(3);
        exp_rd(16'h00A5);
        drive(RD, 9'h101, 16'h0000);
        step(1);

        // Compare flag: CMP=0040 written at timer 0030.
        drive(NOP, 9'h000, 16'h0000);
        wait_cyc(16'h0030);
        drive(WR, 9'h103, 16'h0040);
        step(2);
        exp_rd(16'h0040);
        drive(RD, 9'h103, 16'h0000);
        step(1);
        drive(NOP, 9'h000, 16'h0000);
        wait_cyc(16'h0040);
        chk("irq_before_match", 16'(irq), 16'h0000);
        step(1);
        chk("irq_at_match", 16'(irq), 16'h0001);
        exp_rd(16'h0001); exp_rd(16'h0001); exp_rd(16'h0001);
        drive(RD, 9'h104, 16'h0000);
        step(3);
        drive(NOP, 9'h104, 16'h0000);
        step(1);
        chk("irq_cleared", 16'(irq), 16'h0000);
        exp_rd(16'h0000);
        drive(RD, 9'h104, 16'h0000);
        step(1);

        // Five held pushes into a 4-deep FIFO with the consumer stalled.
        for (int i = 1; i <= 5; i++) begin
            drive(WR, 9'h105, 16'(i * 16'h1111));
            step(2);
            drive(NOP, 9'h105, 16'h0000);
            step(1);
        end
        txq.push_back(16'h1111); txq.push_back(16'h2222);
        txq.push_back(16'h3333); txq.push_back(16'h4444);
        exp_rd(16'h0026);
        drive(RD, 9'h104, 16'h0000);
        step(1);
        drive(NOP, 9'h000, 16'h0000);
        step(1);

        // Push into a full FIFO on the same edge as a pop.
        txq.push_back(16'h6666);
        drive(WR, 9'h105, 16'h6666);
        bus.tx_ready = 1'b1;
        step(1);
        bus.tx_ready = 1'b0;
        drive(NOP, 9'h000, 16'h0000);
        step(1);
        exp_rd(16'h0022);
        drive(RD, 9'h104, 16'h0000);
        step(1);
        drive(NOP, 9'h000, 16'h0000);
        drain("tx_valid_drained");

        // Switch synchronizer latency.
        sw = 8'h3C;
        exp_rd(16'h0000); exp_rd(16'h0000); exp_rd(16'h003C);
        drive(RD, 9'h100, 16'h0000);
        step(3);

        // Reset in the middle of a held TXDATA write.
        drive(WR, 9'h105, 16'h7777);
        step(2);
        chk("tx_valid_prereset", 16'(bus.tx_valid), 16'h0001);
        @(negedge clk) reset_n = 1'b0;
        #1;
        chk("rst2_led", 16'(led), 16'h0000);
        chk("rst2_tx_valid", 16'(bus.tx_valid), 16'h0000);
        chk("rst2_tx_data", bus.tx_data, 16'h0000);
        @(negedge clk) reset_n = 1'b1;
        txq.push_back(16'h7777);
        step(3);
        drive(NOP, 9'h000, 16'h0000);
        step(1);
        exp_rd(16'h0008);
        drive(RD, 9'h104, 16'h0000);
        step(1);
        drive(NOP, 9'h000, 16'h0000);
        drain("tx_valid_after_reset");

        step(2);
        chk("reads_outstanding", 16'(rdq_val.size()), 16'h0000);
        chk("tx_outstanding", 16'(txq.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
